// File: rtl/tennis_pkg.sv
// Shared types and helpers for the LED tennis ball engine.
package tennis_pkg;

   typedef enum logic [2:0] {
      SERVE   = 3'd0,
      MOVE_UP = 3'd1,
      MOVE_DN = 3'd2,
      POINT   = 3'd3,
      OVER    = 3'd4
   } state_t;

   typedef enum logic {
      ONE = 1'b0,
      TWO = 1'b1
   } player_t;

   // Step period after one successful return, floored at min_div.
   function automatic int unsigned next_period(input int unsigned period,
                                               input int unsigned min_div,
                                               input int unsigned shift);
      int unsigned p;
      p = period - (period >> shift);
      return (p < min_div) ? min_div : p;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running step counter: clears on request, wraps on expiry.
module step_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] period,
   output logic         expire_c
);

   logic [W-1:0] cnt;

   assign expire_c = (cnt == period - W'(1));

   // Count up, restarting on clear, expiry or reset.
   always_ff @(posedge clk) begin
      if (!rst || clr || expire_c) cnt <= '0;
      else                          cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/tennis_ball_engine.sv
// Ball engine: serve, rally with speed-up, scoring and match end.
module tennis_ball_engine
   import tennis_pkg::*;
#(
   parameter int unsigned N_POS         = 16,
   parameter int unsigned TICK_DIV      = 25_000_000,
   parameter int unsigned MIN_DIV       = 2_000_000,
   parameter int unsigned SPEEDUP_SHIFT = 3,
   parameter int unsigned HIT_WIN       = 2,
   parameter int unsigned WIN_SCORE     = 7,
   parameter int unsigned PAUSE         = 50_000_000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           button_one,
   input  logic                           button_two,
   output logic [N_POS-1:0]               pos,
   output logic                           ball_return,
   output logic                           point_one,
   output logic                           point_two,
   output logic [$clog2(WIN_SCORE+1)-1:0] score_one,
   output logic [$clog2(WIN_SCORE+1)-1:0] score_two,
   output logic                           match_one,
   output logic                           match_two
);

   localparam int unsigned SW   = $clog2(WIN_SCORE + 1);
   localparam int unsigned TMAX = (TICK_DIV > PAUSE) ? TICK_DIV : PAUSE;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   state_t          state_q, state_d;
   player_t         server_q, server_d, scorer_q, scorer_d;
   logic [TW-1:0]   period_q, period_d;
   logic [N_POS-1:0] pos_d;
   logic            ret_d, p1_d, p2_d, m1_d, m2_d;
   logic [SW-1:0]   s1_d, s2_d;
   logic            b1_q, b2_q;
   logic            press_one_c, press_two_c;
   logic            tmr_clr_c, tmr_exp_c;
   logic [TW-1:0]   tmr_period_c;
   logic            launch_c, hit_c, moving_c, at_end_c, miss_c, step_c, done_c, won_c;
   logic            win_up_c, win_dn_c;

   // Previous button samples; tracked through reset so a held button cannot launch.
   always_ff @(posedge clk) begin
      b1_q <= button_one;
      b2_q <= button_two;
   end

   assign press_one_c = button_one & ~b1_q;
   assign press_two_c = button_two & ~b2_q;

   assign win_up_c = |pos[N_POS-1 -: HIT_WIN];
   assign win_dn_c = |pos[HIT_WIN-1:0];
   assign moving_c = (state_q == MOVE_UP) || (state_q == MOVE_DN);
   assign at_end_c = (state_q == MOVE_UP) ? pos[N_POS-1] : pos[0];
   assign launch_c = (state_q == SERVE) && ((server_q == ONE) ? press_one_c : press_two_c);
   assign hit_c    = ((state_q == MOVE_UP) && press_two_c && win_up_c) ||
                     ((state_q == MOVE_DN) && press_one_c && win_dn_c);
   assign miss_c   = moving_c && !hit_c && tmr_exp_c && at_end_c;
   assign step_c   = moving_c && !hit_c && tmr_exp_c && !at_end_c;
   assign done_c   = (state_q == POINT) && tmr_exp_c;
   assign won_c    = (((scorer_q == ONE) ? score_one : score_two) == SW'(WIN_SCORE));

   assign tmr_clr_c    = launch_c || hit_c || miss_c || done_c ||
                         (state_q == SERVE) || (state_q == OVER);
   assign tmr_period_c = (state_q == POINT) ? TW'(PAUSE) : period_q;

   step_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (tmr_clr_c),
      .period   (tmr_period_c),
      .expire_c (tmr_exp_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= SERVE;
      else      state_q <= state_d;
   end

   // Next-state logic; a hit always wins over a coincident expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SERVE:   if (launch_c) state_d = (server_q == ONE) ? MOVE_UP : MOVE_DN;
         MOVE_UP: if (hit_c) state_d = MOVE_DN; else if (miss_c) state_d = POINT;
         MOVE_DN: if (hit_c) state_d = MOVE_UP; else if (miss_c) state_d = POINT;
         POINT:   if (done_c) state_d = won_c ? OVER : SERVE;
         OVER:    state_d = OVER;
         default: state_d = SERVE;
      endcase
   end

   // Next values for the position, pulses, scores and rally bookkeeping.
   always_comb begin
      pos_d    = pos;
      ret_d    = 1'b0;
      p1_d     = 1'b0;
      p2_d     = 1'b0;
      s1_d     = score_one;
      s2_d     = score_two;
      m1_d     = match_one;
      m2_d     = match_two;
      server_d = server_q;
      scorer_d = scorer_q;
      period_d = period_q;
      if (launch_c) period_d = TW'(TICK_DIV);
      if (hit_c) begin
         ret_d    = 1'b1;
         period_d = TW'(next_period(32'(period_q), MIN_DIV, SPEEDUP_SHIFT));
      end
      if (step_c) begin
         if (state_q == MOVE_UP) pos_d = {pos[N_POS-2:0], 1'b0};
         else                    pos_d = {1'b0, pos[N_POS-1:1]};
      end
      if (miss_c) begin
         pos_d = '1;
         if (state_q == MOVE_UP) begin
            scorer_d = ONE;
            p1_d     = 1'b1;
            if (score_one != SW'(WIN_SCORE)) s1_d = score_one + SW'(1);
         end else begin
            scorer_d = TWO;
            p2_d     = 1'b1;
            if (score_two != SW'(WIN_SCORE)) s2_d = score_two + SW'(1);
         end
      end
      if (done_c) begin
         if (won_c) begin
            pos_d = '0;
            if (scorer_q == ONE) m1_d = 1'b1;
            else                 m2_d = 1'b1;
         end else if (scorer_q == ONE) begin
            server_d = TWO;
            pos_d    = {1'b1, {(N_POS-1){1'b0}}};
         end else begin
            server_d = ONE;
            pos_d    = N_POS'(1);
         end
      end
   end

   // Registered outputs and datapath.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pos         <= N_POS'(1);
         ball_return <= 1'b0;
         point_one   <= 1'b0;
         point_two   <= 1'b0;
         score_one   <= '0;
         score_two   <= '0;
         match_one   <= 1'b0;
         match_two   <= 1'b0;
         server_q    <= ONE;
         scorer_q    <= ONE;
         period_q    <= TW'(TICK_DIV);
      end else begin
         pos         <= pos_d;
         ball_return <= ret_d;
         point_one   <= p1_d;
         point_two   <= p2_d;
         score_one   <= s1_d;
         score_two   <= s2_d;
         match_one   <= m1_d;
         match_two   <= m2_d;
         server_q    <= server_d;
         scorer_q    <= scorer_d;
         period_q    <= period_d;
      end
   end

endmodule

// File: tb/tb_tennis_ball_engine.sv
// Directed bench for tennis_ball_engine with a small-parameter build.
module tb_tennis_ball_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       button_one;
   logic       button_two;
   logic [7:0] pos;
   logic       ball_return, point_one, point_two;
   logic [1:0] score_one, score_two;
   logic       match_one, match_two;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       r, b1, b2;
      int         n;
      logic [7:0] pos;
      logic       ret, p1, p2;
      logic [1:0] s1, s2;
      logic       m1, m2;
   } vec_t;

   vec_t tbl[$];

   tennis_ball_engine #(
      .N_POS(8), .TICK_DIV(4), .MIN_DIV(2), .SPEEDUP_SHIFT(1),
      .HIT_WIN(2), .WIN_SCORE(2), .PAUSE(3)
   ) dut (
      .clk(clk), .rst(rst), .button_one(button_one), .button_two(button_two),
      .pos(pos), .ball_return(ball_return), .point_one(point_one), .point_two(point_two),
      .score_one(score_one), .score_two(score_two),
      .match_one(match_one), .match_two(match_two)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic b1, input logic b2, input int n,
                      input logic [7:0] p, input logic ret, input logic p1, input logic p2,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic m1, input logic m2);
      vec_t v;
      v.r = r; v.b1 = b1; v.b2 = b2; v.n = n; v.pos = p;
      v.ret = ret; v.p1 = p1; v.p2 = p2; v.s1 = s1; v.s2 = s2; v.m1 = m1; v.m2 = m2;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic b1, input logic b2, input int n);
      rst = r; button_one = b1; button_two = b2;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input vec_t v);
      chk({tag, " pos"},       int'(pos),         int'(v.pos));
      chk({tag, " return"},    int'(ball_return), int'(v.ret));
      chk({tag, " point_one"}, int'(point_one),   int'(v.p1));
      chk({tag, " point_two"}, int'(point_two),   int'(v.p2));
      chk({tag, " score_one"}, int'(score_one),   int'(v.s1));
      chk({tag, " score_two"}, int'(score_two),   int'(v.s2));
      chk({tag, " match_one"}, int'(match_one),   int'(v.m1));
      chk({tag, " match_two"}, int'(match_two),   int'(v.m2));
   endtask

   task automatic step_chk(input string tag, input logic r, input logic b1, input logic b2,
                           input int n, input logic [7:0] p);
      vec_t v;
      drive(r, b1, b2, n);
      v.r = r; v.b1 = b1; v.b2 = b2; v.n = n; v.pos = p;
      v.ret = 1'b0; v.p1 = 1'b0; v.p2 = 1'b0; v.s1 = 2'd0; v.s2 = 2'd0;
      v.m1 = 1'b0; v.m2 = 1'b0;
      check_out(tag, v);
   endtask

   initial begin
      rst = 1'b0; button_one = 1'b0; button_two = 1'b0;

      // Reset, serve by one, full flight and miss by two.
      add(0,0,0, 2, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,0,0, 1, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,1,0, 1, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,0,0, 3, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,0,0, 1, 8'h02, 0,0,0, 0,0, 0,0);
      add(1,0,0, 4, 8'h04, 0,0,0, 0,0, 0,0);
      add(1,0,0,20, 8'h80, 0,0,0, 0,0, 0,0);
      add(1,0,0, 3, 8'h80, 0,0,0, 0,0, 0,0);
      add(1,0,0, 1, 8'hFF, 0,1,0, 1,0, 0,0);
      add(1,0,0, 2, 8'hFF, 0,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h80, 0,0,0, 1,0, 0,0);
      add(1,1,0, 1, 8'h80, 0,0,0, 1,0, 0,0);
      add(1,0,0, 3, 8'h80, 0,0,0, 1,0, 0,0);
      // Two serves; rally with speed-up, out-of-window press, floor.
      add(1,0,1, 1, 8'h80, 0,0,0, 1,0, 0,0);
      add(1,0,0, 4, 8'h40, 0,0,0, 1,0, 0,0);
      add(1,0,0,20, 8'h02, 0,0,0, 1,0, 0,0);
      add(1,1,0, 1, 8'h02, 1,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h02, 0,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h04, 0,0,0, 1,0, 0,0);
      add(1,0,0, 6, 8'h20, 0,0,0, 1,0, 0,0);
      add(1,0,1, 1, 8'h20, 0,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h40, 0,0,0, 1,0, 0,0);
      add(1,0,1, 1, 8'h40, 1,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h40, 0,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h20, 0,0,0, 1,0, 0,0);
      add(1,0,0, 2, 8'h10, 0,0,0, 1,0, 0,0);
      add(1,0,0, 6, 8'h02, 0,0,0, 1,0, 0,0);
      add(1,1,0, 1, 8'h02, 1,0,0, 1,0, 0,0);
      add(1,0,0, 2, 8'h04, 0,0,0, 1,0, 0,0);
      add(1,0,0,10, 8'h80, 0,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h80, 0,0,0, 1,0, 0,0);
      // Hit coincident with expiry at the far end: return, no point.
      add(1,0,1, 1, 8'h80, 1,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h80, 0,0,0, 1,0, 0,0);
      add(1,0,0, 1, 8'h40, 0,0,0, 1,0, 0,0);
      // One scores again and wins; presses ignored in OVER.
      add(1,0,0,10, 8'h02, 0,0,0, 1,0, 0,0);
      add(1,1,0, 1, 8'h02, 1,0,0, 1,0, 0,0);
      add(1,0,0,12, 8'h80, 0,0,0, 1,0, 0,0);
      add(1,0,0, 2, 8'hFF, 0,1,0, 2,0, 0,0);
      add(1,0,0, 2, 8'hFF, 0,0,0, 2,0, 0,0);
      add(1,0,0, 1, 8'h00, 0,0,0, 2,0, 1,0);
      add(1,1,1, 4, 8'h00, 0,0,0, 2,0, 1,0);
      add(1,0,0, 2, 8'h00, 0,0,0, 2,0, 1,0);
      // Reset from OVER; two wins the match, period restored on each serve.
      add(0,0,0, 2, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,0,0, 1, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,1,0, 1, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,0,0,24, 8'h40, 0,0,0, 0,0, 0,0);
      add(1,0,1, 1, 8'h40, 1,0,0, 0,0, 0,0);
      add(1,0,0, 2, 8'h20, 0,0,0, 0,0, 0,0);
      add(1,0,0,10, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,0,0, 1, 8'h01, 0,0,0, 0,0, 0,0);
      add(1,0,0, 1, 8'hFF, 0,0,1, 0,1, 0,0);
      add(1,0,0, 3, 8'h01, 0,0,0, 0,1, 0,0);
      add(1,1,0, 1, 8'h01, 0,0,0, 0,1, 0,0);
      add(1,0,0, 4, 8'h02, 0,0,0, 0,1, 0,0);
      add(1,0,0,20, 8'h40, 0,0,0, 0,1, 0,0);
      add(1,0,1, 1, 8'h40, 1,0,0, 0,1, 0,0);
      add(1,0,0,14, 8'hFF, 0,0,1, 0,2, 0,0);
      add(1,0,0, 3, 8'h00, 0,0,0, 0,2, 0,1);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].b1, tbl[i].b2, tbl[i].n);
         check_out($sformatf("row%0d", i), tbl[i]);
      end

      // Reset mid-flight with button one held through reset release.
      step_chk("mr reset",    0,0,0, 2, 8'h01);
      step_chk("mr launch",   1,1,0, 1, 8'h01);
      step_chk("mr flight",   1,0,0, 5, 8'h02);
      step_chk("mr rst edge", 0,1,0, 1, 8'h01);
      step_chk("mr rst hold", 0,1,0, 2, 8'h01);
      step_chk("mr held",     1,1,0, 6, 8'h01);
      step_chk("mr release",  1,0,0, 1, 8'h01);
      step_chk("mr repress",  1,1,0, 1, 8'h01);
      step_chk("mr step",     1,0,0, 4, 8'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tennis_ball_engine.md
# tennis_ball_engine

Parametrised ball engine for the LED tennis game. It generalises the fixed 16-LED debug ball into N positions, a configurable hit window, progressive speed-up on every return, per-player scoring, serve alternation and match termination. It sits between the debounced player buttons and the LED/score display logic, and it drives a one-hot ball position plus event pulses.

## Interface
- N_POS, 16: number of LED positions; ≥ 4.
- TICK_DIV, 25_000_000: clock cycles per ball step at serve speed; ≥ 2.
- MIN_DIV, 2_000_000: floor on cycles per step after speed-ups; 1 ≤ MIN_DIV ≤ TICK_DIV.
- SPEEDUP_SHIFT, 3: each return reduces the step period by period >> SPEEDUP_SHIFT.
- HIT_WIN, 2: number of end positions on each side where a press counts as a hit; 1 ≤ HIT_WIN < N_POS/2.
- WIN_SCORE, 7: points needed to win the match; ≥ 1.
- PAUSE, 50_000_000: cycles spent in POINT before the next serve; ≥ 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- button_one  in  1  player one, debounced, level; player one owns pos[0].
- button_two  in  1  player two, debounced, level; player two owns pos[N_POS-1].
- pos  out  N_POS  one-hot ball position; all-ones during POINT.
- return  out  1  one-cycle pulse on a successful hit by either player.
- point_one / point_two  out  1  one-cycle pulse when the player scores.
- score_one / score_two  out  $clog2(WIN_SCORE+1)  current scores.
- match_one / match_two  out  1  level; set when the player wins, held until reset.

## Operation
- States: SERVE, MOVE_UP (toward N_POS-1), MOVE_DN (toward 0), POINT, OVER.
- Reset: state=SERVE, server=one, pos=1 (bit 0), scores 0, period=TICK_DIV, timer 0, all pulses and match flags 0.
- Press = the edge where the button samples 1 and the previous sample was 0. Held buttons never re-trigger.
- SERVE: the ball sits at the server's end. The server's press launches the ball: it enters MOVE_UP (server one) or MOVE_DN (server two), timer cleared, period=TICK_DIV. The other button is ignored.
- MOVE: on each timer expiry (timer == period-1), pos shifts one place toward the receiver and the timer clears.
- Receiver press while the ball index is within HIT_WIN of the receiver's end:
  - direction reverses, return=1, timer clears;
  - period ← max(MIN_DIV, period − (period >> SPEEDUP_SHIFT)).
- Receiver press outside the window: ignored. The hitter's press: ignored.
- Miss: timer expiry while the ball is at the receiver's end (index 0 or N_POS-1) → hitter scores, pulse point_x, go to POINT.
- POINT: pos all-ones for PAUSE cycles. Then:
  - if the scorer's score == WIN_SCORE → OVER, match_x=1;
  - else → SERVE, with the point loser as server and pos at the loser's end.
- OVER: pos all-zeros, buttons ignored, scores frozen; leaves only on reset.
- Score arithmetic is unsigned, never exceeds WIN_SCORE, and does not wrap.

## Timing
- A press acts on the same edge that samples it: pos, state and the return pulse update on that edge.
- Simultaneous press and timer expiry in the same cycle: the hit wins and no step is taken. This applies at the end position too, so no point is scored.
- Both buttons pressed in the same cycle: each is evaluated by its own rule; only the receiver's press can matter.
- Step period after k returns is deterministic per the formula, evaluated once per return.
- Reset asserted mid-rally or mid-POINT: full reset values on that edge, and no pulse is emitted.
- Pulses are exactly one cycle wide and registered.

## Structure
- tennis_pkg: state enum (SERVE, MOVE_UP, MOVE_DN, POINT, OVER), player encoding (ONE=0, TWO=1), and a function returning the period after a speed-up.
- Sub-module step_timer: a loadable counter with clear, a period input, and an expiry output. It is reused for the POINT pause, loaded with PAUSE.
- Top module: edge detectors, FSM, position register, scores.

## Test plan
Bench parameters: N_POS=8, TICK_DIV=4, MIN_DIV=2, SPEEDUP_SHIFT=1, HIT_WIN=2, WIN_SCORE=2, PAUSE=3.
- Reset, then a button_one press → pos steps 0x01→0x02→…→0x80 every 4 cycles; no button_two press → point_one pulses 4 cycles after reaching 0x80, pos=0xFF for 3 cycles, then SERVE with pos=0x80 (server two).
- Rally: button_two pressed at pos=0x40 → return pulse, direction down, period 4→2. A second return → period stays 2 (floor).
- button_two pressed at pos=0x20 (outside the window) → ignored, and the ball continues.
- Hit coincident with timer expiry at pos=0x80 → return pulse, no point, ball moves to 0x40 on the next expiry.
- Player one scores twice → after the second POINT: match_one=1, pos=0x00, presses ignored. Reset → scores 0, pos=0x01.
- Reset asserted mid-flight, with button_one held through the release of reset → no launch until button_one is released and pressed again.
